// File: rtl/tick_countdown_timer_if.sv
// Control/status bundle for the tick-driven countdown timer.
// The master drives requests and the timebase; the slave (the timer) returns
// the count and the status flags.
interface tick_countdown_timer_if #(
  parameter int WIDTH = 7
);
  logic             tick_in;
  logic             start;
  logic             pause;
  logic             ack;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_out;
  logic             prescaler_en;
  logic             busy;
  logic             done;
  logic             expired;

  modport master (
    output tick_in, start, pause, ack, load_val,
    input  count_out, prescaler_en, busy, done, expired
  );

  modport slave (
    input  tick_in, start, pause, ack, load_val,
    output count_out, prescaler_en, busy, done, expired
  );
endinterface

// File: rtl/tick_countdown_timer.sv
// Countdown timer advanced by an external one-cycle tick strobe.
// start loads a saturated count and runs; pause holds the count; reaching zero
// raises a one-cycle done pulse and a sticky expired flag that ack clears.
// Every output is a flop whose next value is derived from the next state.
module tick_countdown_timer #(
  parameter int WIDTH   = 7,
  parameter int MAX_VAL = 99
) (
  input  logic                 clk,
  input  logic                 rst,
  tick_countdown_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             prescaler_en_q, prescaler_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;
  logic [WIDTH-1:0] load_sat;

  // Clamp a requested load to the largest legal count.
  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  // Next-state and next-output logic; start overrides everything else.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    load_sat = sat_load(bus.load_val);

    if (bus.start) begin
      if (load_sat == '0) begin
        state_d = EXPIRED;
        count_d = '0;
      end else begin
        count_d = load_sat;
        state_d = bus.pause ? PAUSED : RUN;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        RUN: begin
          // A pause wins over a coincident tick, so no decrement is lost or gained.
          if (bus.pause) begin
            state_d = PAUSED;
          end else if (bus.tick_in && (count_q != '0)) begin
            count_d = count_q - ONE_C;
            if (count_q == ONE_C) state_d = EXPIRED;
          end
        end
        PAUSED: begin
          if (!bus.pause) state_d = RUN;
        end
        EXPIRED: begin
          count_d = '0;
          if (bus.ack) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end

    // done fires only on the transition into EXPIRED, never while staying there.
    done_d         = (state_d == EXPIRED) && (state_q != EXPIRED);
    expired_d      = (state_d == EXPIRED);
    busy_d         = (state_d == RUN) || (state_d == PAUSED);
    prescaler_en_d = (state_d == RUN);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      count_q        <= '0;
      prescaler_en_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      expired_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      prescaler_en_q <= prescaler_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      expired_q      <= expired_d;
    end
  end

  assign bus.count_out    = count_q;
  assign bus.prescaler_en = prescaler_en_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.expired      = expired_q;

endmodule

// File: tb/tb_tick_countdown_timer.sv
// Bench for tick_countdown_timer: directed scenarios plus randomized traffic
// checked against a flag-based behavioural model of the countdown.
module tb_tick_countdown_timer;
  localparam int W    = 7;
  localparam int MAXV = 99;

  logic clk = 1'b0;
  logic rst;

  tick_countdown_timer_if #(.WIDTH(W)) bus ();

  tick_countdown_timer #(.WIDTH(W), .MAX_VAL(MAXV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a counter plus "counting", "held" and "expired" flags.
  int m_cnt;
  bit m_active;
  bit m_hold;
  bit m_exp;
  bit m_done;

  function automatic void model_reset();
    m_cnt = 0; m_active = 0; m_hold = 0; m_exp = 0; m_done = 0;
  endfunction

  function automatic void model_step();
    int v;
    if (rst) begin
      model_reset();
      return;
    end
    if (bus.start) begin
      v = (int'(bus.load_val) > MAXV) ? MAXV : int'(bus.load_val);
      if (v == 0) begin
        m_done = !m_exp;
        m_cnt = 0; m_exp = 1; m_active = 0; m_hold = 0;
      end else begin
        m_done = 0;
        m_cnt = v; m_exp = 0; m_active = 1; m_hold = bus.pause;
      end
    end else if (m_exp) begin
      m_done = 0;
      if (bus.ack) m_exp = 0;
    end else if (m_active) begin
      m_done = 0;
      if (m_hold) begin
        if (!bus.pause) m_hold = 0;
      end else if (bus.pause) begin
        m_hold = 1;
      end else if (bus.tick_in && m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_active = 0; m_exp = 1; m_done = 1;
        end
      end
    end else begin
      m_done = 0;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input bit s, input bit p, input bit t, input bit a, input int lv);
    bus.start    = s;
    bus.pause    = p;
    bus.tick_in  = t;
    bus.ack      = a;
    bus.load_val = W'(lv);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    #2;
    checks++;
    if ({bus.count_out, bus.prescaler_en, bus.busy, bus.done, bus.expired} !== '0)
      begin errors++; $display("FAIL reset_async: got %h expected 0", {bus.count_out, bus.prescaler_en, bus.busy, bus.done, bus.expired}); end
    cyc(); cyc();
    rst = 1'b0;
    set_in(0, 1, 1, 1, 0);
    cyc(); cyc();
    checks++;
    if ({bus.count_out, bus.prescaler_en, bus.busy, bus.done, bus.expired} !== '0)
      begin errors++; $display("FAIL reset_idle_hold: got %h expected 0", {bus.count_out, bus.prescaler_en, bus.busy, bus.done, bus.expired}); end
    set_in(0, 0, 0, 0, 0);
  endtask

  task automatic test_basic_countdown();
    int dn = 0;
    set_in(1, 0, 0, 0, 3);
    cyc();
    set_in(0, 0, 0, 0, 3);
    checks++;
    if (bus.count_out !== 7'd3 || bus.busy !== 1'b1 || bus.prescaler_en !== 1'b1)
      begin errors++; $display("FAIL basic_load: got cnt=%0d busy=%b pen=%b expected 3 1 1", bus.count_out, bus.busy, bus.prescaler_en); end
    for (int k = 1; k <= 3; k++) begin
      repeat (99) begin cyc(); dn += int'(bus.done); end
      bus.tick_in = 1'b1;
      cyc();
      dn += int'(bus.done);
      bus.tick_in = 1'b0;
      checks++;
      if (bus.count_out !== W'(3 - k))
        begin errors++; $display("FAIL basic_tick%0d: got %0d expected %0d", k, bus.count_out, 3 - k); end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.expired !== 1'b1 || bus.busy !== 1'b0 || bus.prescaler_en !== 1'b0)
      begin errors++; $display("FAIL basic_expiry: got done=%b exp=%b busy=%b pen=%b expected 1 1 0 0", bus.done, bus.expired, bus.busy, bus.prescaler_en); end
    repeat (5) begin cyc(); dn += int'(bus.done); end
    checks++;
    if (dn != 1 || bus.expired !== 1'b1)
      begin errors++; $display("FAIL basic_done_count: got %0d pulses exp=%b expected 1 pulse exp=1", dn, bus.expired); end
  endtask

  task automatic test_saturate_zero();
    set_in(1, 0, 0, 0, 120);
    cyc();
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (bus.count_out !== 7'd99 || bus.busy !== 1'b1)
      begin errors++; $display("FAIL sat_load: got %0d busy=%b expected 99 1", bus.count_out, bus.busy); end
    set_in(1, 0, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (bus.done !== 1'b1 || bus.expired !== 1'b1 || bus.count_out !== 7'd0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL zero_load: got done=%b exp=%b cnt=%0d busy=%b expected 1 1 0 0", bus.done, bus.expired, bus.count_out, bus.busy); end
    cyc();
    checks++;
    if (bus.done !== 1'b0 || bus.expired !== 1'b1)
      begin errors++; $display("FAIL zero_single_pulse: got done=%b exp=%b expected 0 1", bus.done, bus.expired); end
  endtask

  task automatic test_pause();
    set_in(1, 0, 0, 0, 5);
    cyc();
    set_in(0, 0, 1, 0, 0);
    cyc(); cyc();
    checks++;
    if (bus.count_out !== 7'd3)
      begin errors++; $display("FAIL pause_pre: got %0d expected 3", bus.count_out); end
    set_in(0, 1, 1, 0, 0);
    cyc();
    checks++;
    if (bus.count_out !== 7'd3 || bus.busy !== 1'b1 || bus.prescaler_en !== 1'b0)
      begin errors++; $display("FAIL pause_enter: got cnt=%0d busy=%b pen=%b expected 3 1 0", bus.count_out, bus.busy, bus.prescaler_en); end
    for (int k = 0; k < 3; k++) begin
      bus.tick_in = 1'b0; cyc();
      bus.tick_in = 1'b1; cyc();
      checks++;
      if (bus.count_out !== 7'd3 || bus.busy !== 1'b1 || bus.prescaler_en !== 1'b0)
        begin errors++; $display("FAIL pause_hold%0d: got cnt=%0d busy=%b pen=%b expected 3 1 0", k, bus.count_out, bus.busy, bus.prescaler_en); end
    end
    set_in(0, 0, 0, 0, 0);
    cyc();
    checks++;
    if (bus.count_out !== 7'd3 || bus.busy !== 1'b1 || bus.prescaler_en !== 1'b1)
      begin errors++; $display("FAIL pause_release: got cnt=%0d busy=%b pen=%b expected 3 1 1", bus.count_out, bus.busy, bus.prescaler_en); end
  endtask

  task automatic test_ack_restart();
    set_in(1, 0, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 1, 0);
    cyc();
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (bus.expired !== 1'b0 || bus.busy !== 1'b0 || bus.count_out !== 7'd0)
      begin errors++; $display("FAIL ack_idle: got exp=%b busy=%b cnt=%0d expected 0 0 0", bus.expired, bus.busy, bus.count_out); end
    set_in(1, 0, 0, 0, 0);
    cyc();
    set_in(0, 0, 0, 0, 0);
    cyc();
    set_in(1, 0, 0, 0, 7);
    cyc();
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (bus.count_out !== 7'd7 || bus.busy !== 1'b1 || bus.expired !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("FAIL restart_from_expired: got cnt=%0d busy=%b exp=%b done=%b expected 7 1 0 0", bus.count_out, bus.busy, bus.expired, bus.done); end
    cyc();
    checks++;
    if (bus.done !== 1'b0 || bus.count_out !== 7'd7)
      begin errors++; $display("FAIL restart_no_done: got done=%b cnt=%0d expected 0 7", bus.done, bus.count_out); end
  endtask

  task automatic test_async_reset();
    int dn = 0;
    set_in(1, 0, 0, 0, 4);
    cyc();
    set_in(0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.count_out, bus.prescaler_en, bus.busy, bus.done, bus.expired} !== '0)
      begin errors++; $display("FAIL async_reset_midcycle: got %h expected 0", {bus.count_out, bus.prescaler_en, bus.busy, bus.done, bus.expired}); end
    model_reset();
    cyc();
    rst = 1'b0;
    bus.tick_in = 1'b1;
    repeat (5) begin cyc(); dn += int'(bus.done); end
    bus.tick_in = 1'b0;
    checks++;
    if (bus.count_out !== 7'd0 || bus.busy !== 1'b0 || dn != 0)
      begin errors++; $display("FAIL post_reset_idle: got cnt=%0d busy=%b pulses=%0d expected 0 0 0", bus.count_out, bus.busy, dn); end
  endtask

  task automatic test_start_tick();
    set_in(1, 0, 0, 0, 2);
    cyc();
    set_in(1, 0, 1, 0, 9);
    cyc();
    set_in(0, 0, 0, 0, 0);
    checks++;
    if (bus.count_out !== 7'd9 || bus.busy !== 1'b1)
      begin errors++; $display("FAIL start_over_tick: got cnt=%0d busy=%b expected 9 1", bus.count_out, bus.busy); end
  endtask

  task automatic test_random();
    logic [W+3:0] exp_v, got_v;
    int lv;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 127));
      set_in($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, lv);
      cyc();
      exp_v = {W'(m_cnt), m_active && !m_hold, m_active, m_done, m_exp};
      got_v = {bus.count_out, bus.prescaler_en, bus.busy, bus.done, bus.expired};
      checks++;
      if (got_v !== exp_v)
        begin errors++; $display("FAIL random_cycle%0d: got cnt/pen/busy/done/exp=%h expected %h", i, got_v, exp_v); end
    end
    set_in(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_countdown();
    test_saturate_zero();
    test_pause();
    test_ack_restart();
    test_async_reset();
    test_start_tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_countdown_timer.md
TICK_COUNTDOWN_TIMER -- requirements
Module: tick_countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7, giving the bit width of the count.
REQ-002 The block SHALL have parameter MAX_VAL, default 99, giving the largest loadable count.
REQ-003 Port clk SHALL be an input, 1 bit wide, and the single clock; all state changes on the rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide, with asynchronous active-high reset.
REQ-005 Port tick_in SHALL be an input, 1 bit wide, carrying a one-cycle timebase strobe from the prescaler timeout.
REQ-006 Port start SHALL be an input, 1 bit wide, a level sampled each cycle that requests load-and-run.
REQ-007 Port pause SHALL be an input, 1 bit wide, a level that holds the countdown while high.
REQ-008 Port ack SHALL be an input, 1 bit wide, that clears the expired condition.
REQ-009 Port load_val SHALL be an input, WIDTH bits wide, giving the initial count, sampled with start.
REQ-010 Port count_out SHALL be an output, WIDTH bits wide, giving the registered current count.
REQ-011 Port prescaler_en SHALL be an output, 1 bit wide, that enables the upstream prescaler.
REQ-012 Port busy SHALL be an output, 1 bit wide, high in RUN or PAUSED.
REQ-013 Port done SHALL be an output, 1 bit wide, a one-cycle pulse on expiry.
REQ-014 Port expired SHALL be an output, 1 bit wide, a sticky level high in EXPIRED.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, RUN, PAUSED, EXPIRED; all outputs registered.
REQ-016 In any state, start=1 SHALL load count_out with min(load_val, MAX_VAL) on the next edge; start has highest priority among pause, tick_in and ack.
REQ-017 On start, a loaded value of 0 SHALL go directly to EXPIRED with done=1 for one cycle; a nonzero value SHALL go to RUN, or to PAUSED if pause=1 in the same cycle.
REQ-018 In RUN with tick_in=1 and pause=0, count_out SHALL decrement by 1 on the next edge.
REQ-019 In RUN, tick_in=1 with count_out==1 SHALL set count_out=0, enter EXPIRED, and pulse done for exactly one cycle.
REQ-020 In RUN, pause=1 SHALL enter PAUSED; a tick_in in that same cycle SHALL be ignored, with no decrement.
REQ-021 In PAUSED, tick_in SHALL be ignored; pause=0 SHALL return to RUN on the next edge with count_out unchanged.
REQ-022 In EXPIRED, count_out SHALL hold 0 and expired SHALL be 1; ack=1 without start SHALL go to IDLE, clearing expired on the next edge.
REQ-023 In IDLE, count_out SHALL hold its last value; tick_in, pause and ack SHALL have no effect.
REQ-024 prescaler_en SHALL be 1 exactly when the next state is RUN, so it is asserted in the same cycle busy rises and dropped in the cycle PAUSED/EXPIRED is entered.
REQ-025 busy SHALL be 1 in RUN and PAUSED and 0 in IDLE and EXPIRED.
REQ-026 done SHALL never be high for two consecutive cycles, and SHALL be high only on the cycle EXPIRED is entered.
REQ-027 count_out SHALL never underflow below 0 nor exceed MAX_VAL; a decrement SHALL occur only from a nonzero value.
REQ-028 Any unreachable state encoding SHALL recover to IDLE on the next edge with all outputs at reset values.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force state IDLE, count_out=0, prescaler_en=0, busy=0, done=0, expired=0.
REQ-030 rst asserted mid-countdown SHALL abandon the count with no done pulse; after release the block SHALL remain in IDLE until start.
REQ-031 The first rising edge after rst deasserts SHALL be a normal functional edge.

Verification
REQ-032 Load 3, start pulse, then 3 ticks spaced 100 cycles apart -> count_out 3,2,1,0; one done pulse; expired=1, busy=0, prescaler_en=0.
REQ-033 Load 120, start -> count_out=99 (saturated); load 0, start -> EXPIRED with a single done pulse the next cycle.
REQ-034 Load 5, run 2 ticks, pause with a coincident tick, 3 ticks while paused, then release -> count_out stays 3 while paused; busy=1; prescaler_en=0 while paused.
REQ-035 In EXPIRED: ack -> IDLE, expired=0; a separate start with load_val 7 while in EXPIRED -> RUN with count_out=7 and no further done pulse.
REQ-036 Assert rst asynchronously between edges at count 4 -> outputs zero before the next edge; after release, ticks produce no change until start.
REQ-037 Apply start and tick_in in the same cycle while in RUN at count 2 with load_val 9 -> count_out=9, not 1.
